// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute stage: default widths, ALU control
// encodings and the execute-stage state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_CTRL_W = 4;
   localparam int ALU_REG_W  = 5;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_MULT = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b1001;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1011;
   localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'b1100;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Iterative shift-add multiplier producing the low DATA_W bits of A*B, one
// partial-product step per clock, DATA_W steps in total.
// Ports:
//   clk, rst    clock, synchronous active-high reset (control only)
//   start       load operands and begin iterating
//   abort       stop iterating, discard the partial sum
//   mcandIn     multiplicand (operand A)
//   mplierIn    multiplier (operand B)
//   done        high during the final iteration; product is valid then
//   product     accumulator value after the current iteration
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] mcandIn,
   input  logic [DATA_W-1:0] mplierIn,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

   logic             running;
   logic [CNT_W-1:0] cnt;
   logic [DATA_W-1:0] mcandP0;
   logic [DATA_W-1:0] mplierP0;
   logic [DATA_W-1:0] accP0;
   logic [DATA_W-1:0] accNext;

   // Partial-product step: the sum is exposed combinationally so the final
   // iteration's result can be captured by the consumer on the same edge.
   assign accNext = mplierP0[0] ? (accP0 + mcandP0) : accP0;
   assign product = accNext;
   assign done    = running && (cnt == LAST_ITER);

   // Control: iteration counter and run flag
   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (abort) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
      end else if (running) begin
         if (cnt == LAST_ITER) begin
            running <= 1'b0;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Datapath: operands are always reloaded on start, so no reset is needed
   always_ff @(posedge clk) begin
      if (start) begin
         mcandP0  <= mcandIn;
         mplierP0 <= mplierIn;
         accP0    <= '0;
      end else if (running) begin
         accP0    <= accNext;
         mcandP0  <= mcandP0 << 1;
         mplierP0 <= mplierP0 >> 1;
      end
   end

endmodule

// File: rtl/alu_execute_stage.sv
// -----------------------------------------------------------------------------
// alu_execute_stage
// Registered execute stage: single-cycle ALU ops with latency 1, plus a
// 32-iteration shift-add multiply. One registered result entry with
// valid/ready flow control on both sides.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop in-flight multiply and the output entry
//   in_valid/in_ready   upstream handshake
//   in_a, in_b          operands (shift amount is in_b[4:0])
//   in_alu_ctrl         operation select
//   in_rd               destination tag, passed through to out_rd
//   out_valid/out_ready downstream handshake
//   out_result          registered result
//   out_zero            out_result == 0
//   out_rd              destination tag of the result
//   busy                multiply in progress
// -----------------------------------------------------------------------------
module alu_execute_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int CTRL_W = ALU_CTRL_W,
   parameter int REG_W  = ALU_REG_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [CTRL_W-1:0] in_alu_ctrl,
   input  logic [REG_W-1:0]  in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic [REG_W-1:0]  out_rd,
   output logic              busy
);

   localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // Single-cycle operation mux. MULT and undefined codes yield zero here;
   // MULT is produced by the iterative multiplier instead.
   function automatic logic [DATA_W-1:0] aluCompute(
      input logic [CTRL_W-1:0] ctrl,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic signed [DATA_W-1:0] sa;
      logic signed [DATA_W-1:0] sb;
      logic [SH_W-1:0]          shamt;
      logic [DATA_W-1:0]        res;
      sa    = $signed(a);
      sb    = $signed(b);
      shamt = b[SH_W-1:0];
      res   = '0;
      case (ctrl)
         ALU_AND:  res = a & b;
         ALU_OR:   res = a | b;
         ALU_ADD:  res = a + b;
         ALU_XOR:  res = a ^ b;
         ALU_SUB:  res = a - b;
         ALU_SLT:  res = {{(DATA_W-1){1'b0}}, (sa < sb)};
         ALU_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
         ALU_SLL:  res = a << shamt;
         ALU_SRL:  res = a >> shamt;
         ALU_SRA:  res = sa >>> shamt;
         ALU_NOR:  res = ~(a | b);
         default:  res = '0;
      endcase
      return res;
   endfunction

   function automatic logic isZero(input logic [DATA_W-1:0] v);
      return (v == '0);
   endfunction

   logic [0:0]        state;
   logic              vldP1;
   logic [DATA_W-1:0] resP1;
   logic              zeroP1;
   logic [REG_W-1:0]  rdP1;

   logic              accept;
   logic              isMult;
   logic [DATA_W-1:0] aluRes;
   logic              mulDone;
   logic [DATA_W-1:0] mulProduct;

   // Stage 0: accept decision and combinational ALU result
   assign in_ready = (state == ST_IDLE) && (!vldP1 || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign isMult   = (in_alu_ctrl == ALU_MULT);
   assign aluRes   = aluCompute(in_alu_ctrl, in_a, in_b);

   shift_add_multiplier #(
      .DATA_W (DATA_W)
   ) uMult (
      .clk      (clk),
      .rst      (rst),
      .start    (accept && isMult),
      .abort    (flush),
      .mcandIn  (in_a),
      .mplierIn (in_b),
      .done     (mulDone),
      .product  (mulProduct)
   );

   // Stage 1: registered result entry and state
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         vldP1  <= 1'b0;
         resP1  <= '0;
         zeroP1 <= 1'b0;
         rdP1   <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         vldP1 <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (accept) begin
            // The tag is captured at accept; for MULT the entry stays
            // invalid until the product lands, so out_rd is don't-care then.
            rdP1 <= in_rd;
            if (isMult) begin
               state <= ST_MUL;
               vldP1 <= 1'b0;
            end else begin
               resP1  <= aluRes;
               zeroP1 <= isZero(aluRes);
               vldP1  <= 1'b1;
            end
         end else if (out_ready) begin
            vldP1 <= 1'b0;
         end
      end else begin
         // Output is guaranteed empty while multiplying.
         if (mulDone) begin
            resP1  <= mulProduct;
            zeroP1 <= isZero(mulProduct);
            vldP1  <= 1'b1;
            state  <= ST_IDLE;
         end
      end
   end

   assign out_valid  = vldP1;
   assign out_result = resP1;
   assign out_zero   = zeroP1;
   assign out_rd     = rdP1;
   assign busy       = (state == ST_MUL);

endmodule

// File: tb/tb_alu_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_execute_stage
// Directed-vector bench for alu_execute_stage with hand-computed results.
// -----------------------------------------------------------------------------
module tb_alu_execute_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_alu_ctrl;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic [4:0]  out_rd;
   logic        busy;

   int nVec = 0;
   int nErr = 0;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MULT = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_BAD  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   alu_execute_stage dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_alu_ctrl (in_alu_ctrl),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_zero    (out_zero),
      .out_rd      (out_rd),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op, confirm it will be taken, clock it in, then drop valid.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      in_alu_ctrl = op;
      in_a        = a;
      in_b        = b;
      in_rd       = rd;
      in_valid    = 1'b1;
      #1;
      checkVec("in_ready before accept", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic checkEntry(input string tag, input logic [31:0] res,
                             input logic zero, input logic [4:0] rd);
      checkVec({tag, " valid"}, out_valid, 1);
      checkVec({tag, " result"}, out_result, res);
      checkVec({tag, " zero"}, out_zero, zero);
      checkVec({tag, " rd"}, out_rd, rd);
   endtask

   task automatic checkCleared(input string tag);
      checkVec({tag, " valid"}, out_valid, 0);
      checkVec({tag, " result"}, out_result, 0);
      checkVec({tag, " zero"}, out_zero, 0);
      checkVec({tag, " rd"}, out_rd, 0);
      checkVec({tag, " busy"}, busy, 0);
      checkVec({tag, " in_ready"}, in_ready, 1);
   endtask

   initial begin
      bit sawBad;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_alu_ctrl = '0; in_rd = '0;

      // Reset state
      tick();
      rst = 1'b0;
      #1;
      checkCleared("reset");

      // Signed vs unsigned compares, back to back
      issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3);
      checkEntry("slt -1<1", 32'd1, 1'b0, 5'd3);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4);
      checkEntry("sltu", 32'd0, 1'b1, 5'd4);
      issue(OP_SLT, 32'd5, 32'hFFFF_FFFD, 5'd5);
      checkEntry("slt 5<-3", 32'd0, 1'b1, 5'd5);

      // Throughput: ADD, SUB, NOR on consecutive cycles
      issue(OP_ADD, 32'd7, 32'd9, 5'd1);
      checkEntry("add 7+9", 32'd16, 1'b0, 5'd1);
      issue(OP_SUB, 32'd3, 32'd3, 5'd2);
      checkEntry("sub 3-3", 32'd0, 1'b1, 5'd2);
      issue(OP_NOR, 32'd0, 32'd0, 5'd4);
      checkEntry("nor 0,0", 32'hFFFF_FFFF, 1'b0, 5'd4);

      // Remaining single-cycle ops and shift boundaries
      issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd6);
      checkEntry("and", 32'h00F0_1200, 1'b0, 5'd6);
      issue(OP_OR, 32'hF000_0000, 32'h0000_000F, 5'd7);
      checkEntry("or", 32'hF000_000F, 1'b0, 5'd7);
      issue(OP_SUB, 32'd0, 32'd1, 5'd8);
      checkEntry("sub wrap", 32'hFFFF_FFFF, 1'b0, 5'd8);
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd9);
      checkEntry("add wrap", 32'd0, 1'b1, 5'd9);
      issue(OP_SLL, 32'd1, 32'd31, 5'd10);
      checkEntry("sll 31", 32'h8000_0000, 1'b0, 5'd10);
      issue(OP_SLL, 32'd1, 32'h0000_0021, 5'd11);
      checkEntry("sll uses b[4:0]", 32'd2, 1'b0, 5'd11);
      issue(OP_SRL, 32'h8000_0000, 32'd4, 5'd12);
      checkEntry("srl", 32'h0800_0000, 1'b0, 5'd12);
      issue(OP_SRA, 32'h8000_0000, 32'd4, 5'd13);
      checkEntry("sra", 32'hF800_0000, 1'b0, 5'd13);
      issue(OP_BAD, 32'h1234_5678, 32'h1111_1111, 5'd14);
      checkEntry("undefined op", 32'd0, 1'b1, 5'd14);
      tick();
      checkVec("drain valid", out_valid, 0);

      // Backpressure: entry held for 4 cycles, pending op taken on release
      out_ready = 1'b0;
      issue(OP_ADD, 32'd100, 32'd23, 5'd7);
      checkEntry("bp add", 32'd123, 1'b0, 5'd7);
      in_alu_ctrl = OP_XOR; in_a = 32'h0000_F0F0; in_b = 32'h0000_0FF0; in_rd = 5'd8;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkVec("bp in_ready low", in_ready, 0);
         tick();
         checkEntry("bp hold", 32'd123, 1'b0, 5'd7);
      end
      out_ready = 1'b1;
      #1;
      checkVec("bp release in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      checkEntry("bp xor", 32'h0000_FF00, 1'b0, 5'd8);
      tick();
      checkVec("bp drain valid", out_valid, 0);

      // MULT latency and busy window
      issue(OP_MULT, 32'h0001_2345, 32'h0000_0100, 5'd15);
      sawBad = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         if (!busy || in_ready || out_valid) sawBad = 1'b1;
         tick();
      end
      checkVec("mult busy window", {31'd0, sawBad}, 0);
      checkVec("mult not done early", out_valid, 0);
      checkVec("mult busy at T+31", busy, 1);
      tick();
      checkEntry("mult 0x12345*0x100", 32'h0123_4500, 1'b0, 5'd15);
      checkVec("mult busy cleared", busy, 0);
      tick();

      issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 5'd16);
      repeat (31) tick();
      checkVec("mult2 not done early", out_valid, 0);
      tick();
      checkEntry("mult -1*2", 32'hFFFF_FFFE, 1'b0, 5'd16);
      tick();

      // Flush at iteration 10 of a multiply
      issue(OP_MULT, 32'd3, 32'd5, 5'd17);
      repeat (10) tick();
      checkVec("flush pre busy", busy, 1);
      flush = 1'b1;
      in_alu_ctrl = OP_ADD; in_a = 32'd50; in_b = 32'd50; in_rd = 5'd18;
      in_valid = 1'b1;
      #1;
      checkVec("flush in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checkVec("flush busy", busy, 0);
      checkVec("flush valid", out_valid, 0);
      issue(OP_ADD, 32'd2, 32'd2, 5'd19);
      checkEntry("add after flush", 32'd4, 1'b0, 5'd19);
      sawBad = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (out_valid || busy) sawBad = 1'b1;
      end
      checkVec("flushed mult never completes", {31'd0, sawBad}, 0);

      // Reset mid-multiply
      issue(OP_MULT, 32'd7, 32'd7, 5'd20);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checkCleared("reset mid-mult");
      repeat (35) tick();
      checkVec("no result after reset", out_valid, 0);

      // Reset while an entry is held
      out_ready = 1'b0;
      issue(OP_ADD, 32'd1, 32'd1, 5'd21);
      checkEntry("held entry", 32'd2, 1'b0, 5'd21);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      checkCleared("reset held entry");
      issue(OP_OR, 32'h0000_00A0, 32'h0000_000B, 5'd22);
      checkEntry("op after reset", 32'h0000_00AB, 1'b0, 5'd22);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
Registered execute stage of the MIPS-style datapath. It sits between the decode/operand-read stage and the memory stage. It accepts one operation per handshake and computes all single-cycle ALU ops, including the set-on-less-than results. It also runs an iterative 32-cycle shift-add multiply, and presents one registered result with valid/ready flow control.

Parameters:
DATA_W, 32, operand/result width; also the multiply iteration count
CTRL_W, 4, ALU control field width
REG_W, 5, destination register index width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
flush  input  1  discard in-flight op and output entry (branch/exception)
in_valid  input  1  upstream offers an operation
in_ready  output  1  stage accepts on this edge when in_valid is high
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B; shift amount is in_b[4:0]
in_alu_ctrl  input  CTRL_W  operation select
in_rd  input  REG_W  destination register tag, passed through
out_valid  output  1  result entry valid
out_ready  input  1  downstream consumes entry on this edge
out_result  output  DATA_W  registered result
out_zero  output  1  out_result == 0
out_rd  output  REG_W  tag of the result
busy  output  1  multiply in progress

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; out_valid, out_result, out_zero, out_rd, busy, iteration counter all 0. rst has priority over flush and all handshakes.
- Opcode encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 MULT, 0100 XOR
  - 0110 SUB, 0111 SLT, 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 NOR
  - any other code: result 0
- Arithmetic:
  - ADD/SUB wrap modulo 2^32; no overflow trap.
  - SLT is a two's-complement signed compare: result 1 if A<B, else 0, zero-extended.
  - SLTU is an unsigned compare.
  - Shifts use in_b[4:0] and shift A.
  - MULT returns the low 32 bits of the product; signedness is irrelevant for the low half.
- Accept rule: in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. An op is accepted when in_valid && in_ready at an edge.
- Single-cycle op accepted at edge T: out_result/out_zero/out_rd loaded and out_valid=1 after edge T. Latency 1.
- Back-to-back: in_ready stays high while out_ready=1, giving one op per cycle of throughput.
- Entry hold: out_valid stays 1 and outputs stay stable until out_ready=1 at an edge. Then out_valid clears, unless a new op is accepted at the same edge, which replaces the entry.
- State machine:
  - IDLE, on accept of MULT -> MUL: load multiplicand=A, multiplier=B, acc=0, cnt=0, busy=1.
  - MUL: each edge, if multiplier[0] then acc+=multiplicand; multiplicand<<=1, multiplier>>=1, cnt++.
  - MUL, on the edge where cnt==DATA_W-1 (32nd iteration): final acc is written to out_result; out_valid=1, busy=0, state -> IDLE.
  - MULT accepted at edge T therefore gives out_valid after edge T+32.
  - MUL never starts while an unconsumed entry exists, because accept requires the output to be free.
- Flush at an edge:
  - out_valid -> 0.
  - In MUL: abort to IDLE, busy -> 0, partial acc discarded, no result produced.
  - in_valid ignored that cycle.
  - out_result/out_rd keep stale values; they are don't-care while out_valid=0.
- Simultaneous events:
  - flush with out_ready: flush wins and nothing is accepted.
  - MULT completion with out_ready=1 and stale entry: not possible, since MUL only runs with the output empty.
- X-free: no output depends on in_* when the op is not accepted.

Decomposition:
- Package alu_pkg holds:
  - ALU_AND..ALU_NOR localparams (CTRL_W-bit codes)
  - state encoding IDLE/MUL
  - DATA_W/REG_W defaults
- One sub-module: shift_add_multiplier, containing the counter, shift registers, accumulator and done pulse. The combinational op mux stays in alu_execute_stage.

Test Plan:
- SLT signedness: A=0xFFFFFFFF, B=0x00000001 -> out_result=1. Same operands with SLTU -> 0. A=5, B=-3 with SLT -> 0.
- Back-to-back throughput, out_ready=1: ADD 7+9, SUB 3-3, NOR 0,0 on consecutive cycles -> results 16 (zero=0), 0 (zero=1), 0xFFFFFFFF, each one cycle after accept, with out_rd tags preserved.
- Backpressure: out_ready=0 for 4 cycles after an ADD result -> out_valid stays 1, entry stable, in_ready=0. Release -> next op accepted on the same edge.
- MULT: A=0x00012345, B=0x00000100, accepted at edge T:
  - busy=1 and in_ready=0 for 32 cycles.
  - out_valid after T+32 with out_result=0x01234500.
  - Also A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE.
- Flush mid-MULT at iteration 10 -> busy=0, out_valid never asserts for that op, next ADD accepted the following cycle.
- Reset mid-MULT and while an entry is held -> all outputs 0, state IDLE, in_ready=1 on the next cycle.
